// File: rtl/execute_pkg.sv
// execute_pkg: shared encodings for the EX stage.
//   ALU op codes (ALUselE), branch condition codes (funct3E),
//   operand forward select codes (forwardAE/forwardBE),
//   writeback select codes (wbselE/wbselM), multiplier FSM states.
package execute_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;

    localparam logic [2:0] BR_EQ = 3'b000;
    localparam logic [2:0] BR_NE = 3'b001;
    localparam logic [2:0] BR_LT = 3'b100;
    localparam logic [2:0] BR_GE = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/execute_alu.sv
// alu: combinational 32-bit ALU, wrap-around arithmetic.
//   a_i, b_i : operands
//   sel_i    : op code (add/sub/and/or/xor; any other code adds)
//   y_o      : result
module alu
    import execute_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  sel_i,
    output logic [31:0] y_o
);

    always_comb begin
        case (sel_i)
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            default: y_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/execute.sv
// execute: EX stage with operand forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register.
//   clk, rst            : clock, synchronous active-high reset
//   *E inputs           : decoded control/operands for the instruction in EX
//   forwardAE/BE,resultW: operand forwarding selects and writeback value
//   pcselE, pctargetE   : fetch redirect (combinational)
//   stallE              : EX busy, freezes F/D/E
//   *M outputs          : EX/MEM register contents
// Build option: EXECUTE_MUL_EN adds a 32-cycle shift-add multiplier on
// ALUselE=101; without it 101 adds and stallE is constant 0.
module execute
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        regwriteE,
    input  logic        memrwE,
    input  logic        brunE,
    input  logic        branchE,
    input  logic        jumpE,
    input  logic        bselE,
    input  logic [1:0]  wbselE,
    input  logic [2:0]  ALUselE,
    input  logic [2:0]  funct3E,
    input  logic [4:0]  rdE,
    input  logic [31:0] rd1E,
    input  logic [31:0] rd2E,
    input  logic [31:0] imm_exE,
    input  logic [31:0] pcE,
    input  logic [31:0] pc4E,
    input  logic [1:0]  forwardAE,
    input  logic [1:0]  forwardBE,
    input  logic [31:0] resultW,
    output logic        pcselE,
    output logic [31:0] pctargetE,
    output logic        stallE,
    output logic        regwriteM,
    output logic        memrwM,
    output logic [1:0]  wbselM,
    output logic [4:0]  rdM,
    output logic [31:0] aluresultM,
    output logic [31:0] writedataM,
    output logic [31:0] pc4M
);

    logic [31:0] fwd_a, fwd_b, src_b, alu_y, ex_result;
    logic        cond, stall_e;

    logic        regwrite_q, regwrite_d, memrw_q, memrw_d;
    logic [1:0]  wbsel_q, wbsel_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] alures_q, alures_d, wdata_q, wdata_d, pc4_q, pc4_d;

    // Code 11 falls back to the register file value.
    always_comb begin
        case (forwardAE)
            FWD_WB:  fwd_a = resultW;
            FWD_MEM: fwd_a = alures_q;
            default: fwd_a = rd1E;
        endcase
        case (forwardBE)
            FWD_WB:  fwd_b = resultW;
            FWD_MEM: fwd_b = alures_q;
            default: fwd_b = rd2E;
        endcase
    end

    assign src_b = bselE ? imm_exE : fwd_b;

    alu u_alu (
        .a_i   (fwd_a),
        .b_i   (src_b),
        .sel_i (ALUselE),
        .y_o   (alu_y)
    );

    always_comb begin
        case (funct3E)
            BR_EQ:   cond = (fwd_a == fwd_b);
            BR_NE:   cond = (fwd_a != fwd_b);
            BR_LT:   cond = brunE ? (fwd_a < fwd_b) : ($signed(fwd_a) < $signed(fwd_b));
            BR_GE:   cond = brunE ? (fwd_a >= fwd_b) : ($signed(fwd_a) >= $signed(fwd_b));
            default: cond = 1'b0;
        endcase
    end

    assign pcselE    = (jumpE | (branchE & cond)) & ~stall_e;
    assign pctargetE = (jumpE & bselE) ? ((fwd_a + imm_exE) & ~32'h1) : (pcE + imm_exE);

`ifdef EXECUTE_MUL_EN
    mul_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] mcand_q, mplier_q, prod_q;
    logic        mul_op;

    assign mul_op = (ALUselE == ALU_MUL);

    // One multiplier bit per BUSY cycle; DONE hands the product to EX/MEM
    // and must not re-trigger even though the MUL is still held in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= 5'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            prod_q   <= 32'd0;
        end else begin
            case (state_q)
                MUL_IDLE: if (mul_op) begin
                    state_q  <= MUL_BUSY;
                    cnt_q    <= 5'd0;
                    mcand_q  <= fwd_a;
                    mplier_q <= src_b;
                    prod_q   <= 32'd0;
                end
                MUL_BUSY: begin
                    if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= MUL_DONE;
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

    assign stall_e   = ((state_q == MUL_IDLE) & mul_op) | (state_q == MUL_BUSY);
    assign ex_result = (state_q == MUL_DONE) ? prod_q : alu_y;
`else
    assign stall_e   = 1'b0;
    assign ex_result = alu_y;
`endif

    assign stallE = stall_e;

    // Stalled cycles push a bubble; data fields hold so forwarding stays stable.
    always_comb begin
        regwrite_d = regwriteE;
        memrw_d    = memrwE;
        wbsel_d    = wbselE;
        rd_d       = rdE;
        alures_d   = ex_result;
        wdata_d    = fwd_b;
        pc4_d      = pc4E;
        if (stall_e) begin
            regwrite_d = 1'b0;
            memrw_d    = 1'b0;
            wbsel_d    = 2'b00;
            rd_d       = 5'd0;
            alures_d   = alures_q;
            wdata_d    = wdata_q;
            pc4_d      = pc4_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            memrw_q    <= 1'b0;
            wbsel_q    <= 2'b00;
            rd_q       <= 5'd0;
            alures_q   <= 32'd0;
            wdata_q    <= 32'd0;
            pc4_q      <= 32'd0;
        end else begin
            regwrite_q <= regwrite_d;
            memrw_q    <= memrw_d;
            wbsel_q    <= wbsel_d;
            rd_q       <= rd_d;
            alures_q   <= alures_d;
            wdata_q    <= wdata_d;
            pc4_q      <= pc4_d;
        end
    end

    assign regwriteM  = regwrite_q;
    assign memrwM     = memrw_q;
    assign wbselM     = wbsel_q;
    assign rdM        = rd_q;
    assign aluresultM = alures_q;
    assign writedataM = wdata_q;
    assign pc4M       = pc4_q;

endmodule
